// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and types for the 7-segment display arbitration slice.
//   SEG_BLANK          : one blank digit (all active-low segments off)
//   GRANT_*            : one-hot display owner encodings
//   state_t            : arbiter state (score shown / face-or-alert held)
//   EYES, *_MOUTH      : face glyphs used by face producers and benches
//   face_image()       : packs a face glyph pair into a 4-digit image
// -----------------------------------------------------------------------------
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [2:0] GRANT_SCORE = 3'b001;
    localparam logic [2:0] GRANT_ALERT = 3'b010;
    localparam logic [2:0] GRANT_FACE  = 3'b100;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    localparam logic [6:0] HAPPY_MOUTH = 7'b1110000;
    localparam logic [6:0] SAD_MOUTH   = 7'b1000110;
    localparam logic [6:0] EYES        = 7'b1110110;

    // Eyes on HEX3, mouth on HEX2, the two low digits blank.
    function automatic logic [27:0] face_image(input logic [6:0] eyes,
                                               input logic [6:0] mouth);
        return {eyes, mouth, SEG_BLANK, SEG_BLANK};
    endfunction

endpackage

// File: rtl/disp_hold_counter.sv
// -----------------------------------------------------------------------------
// disp_hold_counter
// Counts 1 s ticks while a face/alert grant is held and flags the last one.
//   clk, rst : clock, synchronous active-low reset
//   clear    : restart the count at 0 (grant entry, including back-to-back)
//   enable   : count only while the arbiter is holding
//   tick     : one-cycle pulse per second
//   expire   : combinational pulse on the HOLD_TICKS-th counted tick
// -----------------------------------------------------------------------------
module disp_hold_counter #(
    parameter int HOLD_TICKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expire
);

    localparam int W = $clog2(HOLD_TICKS + 1);
    localparam logic [W-1:0] LAST = W'(HOLD_TICKS - 1);

    logic [W-1:0] cnt;

    assign expire = enable && tick && (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || expire) begin
            // Wrapping on expiry keeps cnt at or below HOLD_TICKS-1.
            cnt <= '0;
        end else if (enable && tick) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
// Time-shares the 4-digit active-low 7-segment display between face (highest),
// alert (middle) and the live score (default). Face/alert requests are latched,
// granted, snapshotted and held for HOLD_TICKS seconds, then the score returns.
//   clk, rst                 : clock, synchronous active-low reset
//   tick                     : 1 s pulse from the shared timer
//   req_face, face_eyes/mouth: face request pulse and glyphs
//   req_alert, alert_seg     : alert request pulse and 4-digit image
//   score_seg                : live score image
//   seg_out                  : registered display image
//   grant                    : one-hot owner (001 score, 010 alert, 100 face)
//   tick_enable              : runs the shared second timer during a hold
//   busy                     : face or alert hold in progress
// -----------------------------------------------------------------------------
module display_arbiter
    import display_pkg::*;
#(
    parameter int HOLD_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        req_face,
    input  logic [6:0]  face_eyes,
    input  logic [6:0]  face_mouth,
    input  logic        req_alert,
    input  logic [27:0] alert_seg,
    input  logic [27:0] score_seg,
    output logic [27:0] seg_out,
    output logic [2:0]  grant,
    output logic        tick_enable,
    output logic        busy
);

    state_t      state, state_n;
    logic        pend_face, pend_face_n;
    logic        pend_alert, pend_alert_n;
    logic [27:0] seg_n;
    logic [2:0]  grant_n;
    logic        tick_enable_n;
    logic        busy_n;
    logic        take_face, take_alert;
    logic        cnt_clear;
    logic        expire;

    disp_hold_counter #(
        .HOLD_TICKS (HOLD_TICKS)
    ) u_hold_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (state == ST_HOLD),
        .tick   (tick),
        .expire (expire)
    );

    // NOTE: every signal driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n       = state;
        seg_n         = seg_out;
        grant_n       = grant;
        tick_enable_n = tick_enable;
        busy_n        = busy;
        take_face     = 1'b0;
        take_alert    = 1'b0;
        cnt_clear     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                seg_n         = score_seg;
                grant_n       = GRANT_SCORE;
                tick_enable_n = 1'b0;
                busy_n        = 1'b0;
                if (req_face || pend_face) begin
                    take_face = 1'b1;
                end else if (req_alert || pend_alert) begin
                    take_alert = 1'b1;
                end
            end
            ST_HOLD: begin
                // Only latched requests chain at expiry; a pulse arriving on
                // the expiry edge is latched and served from IDLE next cycle.
                if (expire) begin
                    if (pend_face) begin
                        take_face = 1'b1;
                    end else if (pend_alert) begin
                        take_alert = 1'b1;
                    end else begin
                        state_n       = ST_IDLE;
                        seg_n         = score_seg;
                        grant_n       = GRANT_SCORE;
                        tick_enable_n = 1'b0;
                        busy_n        = 1'b0;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Grant entry: snapshot the source once and restart the hold count.
        if (take_face) begin
            state_n       = ST_HOLD;
            seg_n         = face_image(face_eyes, face_mouth);
            grant_n       = GRANT_FACE;
            tick_enable_n = 1'b1;
            busy_n        = 1'b1;
            cnt_clear     = 1'b1;
        end else if (take_alert) begin
            state_n       = ST_HOLD;
            seg_n         = alert_seg;
            grant_n       = GRANT_ALERT;
            tick_enable_n = 1'b1;
            busy_n        = 1'b1;
            cnt_clear     = 1'b1;
        end

        // A grant absorbs a same-cycle request for the same source; repeated
        // pulses otherwise collapse into one pending bit.
        pend_face_n  = take_face  ? 1'b0 : (pend_face  || req_face);
        pend_alert_n = take_alert ? 1'b0 : (pend_alert || req_alert);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pend_face   <= 1'b0;
            pend_alert  <= 1'b0;
            seg_out     <= {4{SEG_BLANK}};
            grant       <= GRANT_SCORE;
            tick_enable <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            pend_face   <= pend_face_n;
            pend_alert  <= pend_alert_n;
            seg_out     <= seg_n;
            grant       <= grant_n;
            tick_enable <= tick_enable_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Time-shares the 4-digit active-low 7-segment display among three sources: face (highest priority), alert (middle) and score (background default). Face and alert are one-cycle request pulses. Each one is latched, granted, snapshotted and held for a fixed number of 1 s ticks from the shared second timer, then the display returns to the live score. It sits between the face/alert producers and the display driver, and it owns the timer's enable.

## Interface
- HOLD_TICKS, 2, number of `tick` pulses a face/alert grant is held; legal range ≥1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- tick  in  1  one-cycle pulse per second from the shared timer; only meaningful while `tick_enable`=1.
- req_face  in  1  one-cycle request to show a face.
- face_eyes  in  7  face eye glyph, active-low segments.
- face_mouth  in  7  face mouth glyph, active-low segments.
- req_alert  in  1  one-cycle request to show an alert.
- alert_seg  in  28  four alert digits, [27:21]=HEX3 … [6:0]=HEX0.
- score_seg  in  28  live score digits, same packing.
- seg_out  out  28  registered display image.
- grant  out  3  one-hot owner: 001 score, 010 alert, 100 face.
- tick_enable  out  1  run the second timer.
- busy  out  1  face or alert grant in progress.

## Operation
- States: IDLE (score shown), HOLD (face or alert shown).
- Pending bits `pend_face` and `pend_alert` latch request pulses in any state.
- A pending bit clears only in the cycle its grant is taken.
- A request arriving in the same cycle as its grant is absorbed by that grant.
- IDLE:
  - `seg_out` tracks `score_seg` each cycle; `grant`=001.
  - If `req_face|pend_face`, go to HOLD with owner=face.
  - Else if `req_alert|pend_alert`, go to HOLD with owner=alert.
- On entering HOLD, snapshot the display once:
  - Face: `seg_out`={face_eyes, face_mouth, 7'h7F, 7'h7F}.
  - Alert: `seg_out`=alert_seg.
  - Set `cnt`=0, `tick_enable`=1, `busy`=1.
  - Source changes during HOLD are ignored.
- HOLD:
  - Each `tick` increments `cnt`.
  - On a `tick` with `cnt`=HOLD_TICKS-1, the hold expires.
- On expiry:
  - If `pend_face`, re-enter HOLD with a face snapshot (back-to-back).
  - Else if `pend_alert`, re-enter HOLD with an alert snapshot.
  - Else go to IDLE with `tick_enable`=0, `busy`=0, `grant`=001, `seg_out`=score_seg.
- No preemption: a face request during an alert hold waits for expiry.
- A repeated request for the current owner is queued as one further hold; multiple pulses collapse into one.
- `cnt` width is $clog2(HOLD_TICKS+1); it never exceeds HOLD_TICKS-1.
- `tick` outside HOLD is ignored.
- Reset (rst=0 at a clk edge), from any state including mid-hold:
  - State IDLE; pending bits 0; `cnt` 0.
  - `seg_out`=28'hFFFFFFF (blank); `grant`=001; `tick_enable`=0; `busy`=0.

## Timing
- All outputs are registered.
- Request → display: a request in cycle n gives the new `seg_out`, `grant`, `busy` and `tick_enable`=1 visible in cycle n+1, provided the state is IDLE in cycle n.
- IDLE score latency: `seg_out` equals `score_seg` delayed by one cycle.
- Expiry: the final tick in cycle m gives the next owner or the score visible in cycle m+1.
  - On return to IDLE, `tick_enable` drops in cycle m+1.
  - On a back-to-back grant, `tick_enable` stays high and `cnt` restarts at 0.
- Simultaneous `req_face` and `req_alert` in IDLE: face is granted, alert stays pending.
- A `tick` coinciding with a grant-entry edge is not counted.
- Counting starts with the first tick seen while in HOLD.
- Reset has priority over every event in the same cycle.

## Structure
- Package `display_pkg`:
  - `SEG_BLANK`=7'h7F.
  - Grant encodings GRANT_SCORE, GRANT_ALERT, GRANT_FACE.
  - State enum {ST_IDLE, ST_HOLD}.
  - Face glyph constants HAPPY_MOUTH=7'b1110000, SAD_MOUTH=7'b1000110, EYES=7'b1110110, for benches and producers.
- One sub-module `disp_hold_counter` (parameter HOLD_TICKS):
  - Inputs: clear, enable, tick.
  - Output: `expire`, a combinational pulse on the final tick.
- Arbitration, pending latches and snapshot mux stay in `display_arbiter`.

## Test plan
- Reset, then `score_seg`=28'h0123456 → next cycle `seg_out`=28'h0123456, `grant`=001, `tick_enable`=0.
- `req_face` pulse with eyes=7'b1110110, mouth=7'b1110000 (HOLD_TICKS=2) → next cycle `seg_out`={1110110,1110000,7F,7F}, `grant`=100, `busy`=1. After the 2nd tick, `seg_out`=score and `tick_enable`=0.
- `req_face` and `req_alert` in the same cycle → face held 2 ticks, then alert shown back-to-back (`tick_enable` never drops), then score.
- `req_face` during an alert hold → alert completes its 2 ticks, then face is shown. A change of `face_eyes` mid-hold does not alter `seg_out`.
- Ticks while IDLE (×5), then `req_alert` → the hold still lasts exactly 2 ticks after the grant.
- rst=0 one cycle after the first tick of a face hold → `seg_out`=28'hFFFFFFF, `grant`=001, `busy`=0, pending cleared. A pre-reset queued alert is not shown.
